pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, default 5, register-address width.
REQ-002 Parameter: CNT_WIDTH, default 16, stall-counter width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 id_valid  in  1  valid instruction in ID.
REQ-006 id_rs1_addr, id_rs2_addr  in  ADDR_WIDTH each  ID source registers.
REQ-007 id_rs_used  in  2  bit0 rs1 read, bit1 rs2 read.
REQ-008 id_rd_addr  in  ADDR_WIDTH  ID destination; id_rd_wr in 1 writes regfile; id_is_load in 1 data-memory load.
REQ-009 ex_branch_taken  in  1  branch/jump resolved taken in EX.
REQ-010 dmem_busy  in  1  data memory not complete this cycle.
REQ-011 pc_inc, pc_load  out  1 each  PC increment / load branch target.
REQ-012 if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline-register write enables.
REQ-013 if_id_flush, id_ex_bubble  out  1 each  clear IF/ID to NOP; load NOP into ID/EX.
REQ-014 wb_wr_en  out  1  qualified regfile write enable.
REQ-015 fwd_a_sel, fwd_b_sel  out  2 each  operand source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB data.
REQ-016 stall_cnt  out  CNT_WIDTH  stall-cycle count.

Function
REQ-017 Stage scoreboard: valid, rd, rd_wr, is_load registered for EX, MEM, WB; shift one stage per cycle when enables high.
REQ-018 Bubble/flush enters scoreboard as valid=0; WB entry retires after one cycle.
REQ-019 Hazard match: stage valid, rd_wr=1, rd!=0, rd equals a used ID source, id_valid=1; rd=0 never matches.
REQ-020 Load-use stall: EX match with is_load=1 -> pc_inc=0, if_id_en=0, id_ex_bubble=1; EX/MEM, MEM/WB advance.
REQ-021 Branch: ex_branch_taken=1, dmem_busy=0 -> pc_load=1, pc_inc=0, if_id_flush=1, id_ex_bubble=1, same cycle; overrides load-use stall.
REQ-022 Freeze: dmem_busy=1 -> all enables, pc_inc, pc_load, flush, bubble, wb_wr_en 0; scoreboard holds; overrides branch and stall.
REQ-023 Free-run (no hazard, branch, busy): all enables=1, pc_inc=1, others 0.
REQ-024 wb_wr_en = WB valid & WB rd_wr & WB rd!=0 & !dmem_busy.
REQ-025 Hazard, flush and forward outputs combinational from ID inputs and registered scoreboard, zero-cycle latency.
REQ-026 Stall cycle = REQ-020 or REQ-030 stall with dmem_busy=0; stall_cnt +1 per stall cycle, saturates at all-ones, no wrap.
REQ-027 Simultaneous stall and freeze: count not incremented (freeze cycle only).

Reset
REQ-028 rst high: all scoreboard valids 0, stall_cnt 0, every output 0 (async, independent of clk).
REQ-029 First cycle after deassertion: free-run outputs per REQ-023; reset mid-stall discards stall and in-flight entries.

Configuration
REQ-030 Macro PIPELINE_CTRL_FORWARDING_EN defined: fwd_*_sel per match priority EX/MEM(non-load) 01 > MEM/WB 10 > 00; only load-use stalls.
REQ-031 Macro undefined: fwd_*_sel tied 00; any match in EX, MEM or WB stalls per REQ-020 until writer retires.

Verification
REQ-032 Load x5 in EX, ID add reads x5 (rs1) -> one cycle pc_inc=0, id_ex_bubble=1; next cycle fwd_a_sel=10 (FORWARDING_EN), stall_cnt=1.
REQ-033 Add writes x3, next reads x3 via rs2 -> FORWARDING_EN: fwd_b_sel=01 no stall; undefined: 3 stall cycles, stall_cnt=3.
REQ-034 ex_branch_taken=1 during load-use stall -> pc_load=1, if_id_flush=1, id_ex_bubble=1, pc_inc=0, counter unchanged.
REQ-035 dmem_busy=1 for 4 cycles with branch pending -> all enables 0 for 4 cycles, pc_load=1 only in first non-busy cycle.
REQ-036 Writer rd=0, reader rs1=0 -> no stall, fwd_a_sel=00, wb_wr_en=0 at WB.
REQ-037 CNT_WIDTH=4, 20 stall cycles -> stall_cnt=15; rst pulse mid-stall -> all outputs 0 immediately, stall_cnt=0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if -- bundle of signals between a 5-stage in-order pipeline
// datapath (master) and its hazard/forwarding controller (slave).
//
// Parameters: ADDR_WIDTH register-address width, CNT_WIDTH stall-counter width.
// master drives: id_valid, id_rs1_addr, id_rs2_addr, id_rs_used, id_rd_addr,
//                id_rd_wr, id_is_load, ex_branch_taken, dmem_busy
// slave drives:  pc_inc, pc_load, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//                if_id_flush, id_ex_bubble, wb_wr_en, fwd_a_sel, fwd_b_sel,
//                stall_cnt
//
// Qualifier semantics: there is no ready back-pressure on this bus. The ID
// fields are meaningful only while id_valid is 1, and the datapath keeps the
// same ID instruction on the bus for as long as the controller holds
// if_id_en at 0 (stall or freeze). dmem_busy is sampled every cycle and wins
// over every other request.
interface pipeline_ctrl_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
);
   logic                  id_valid;
   logic [ADDR_WIDTH-1:0] id_rs1_addr;
   logic [ADDR_WIDTH-1:0] id_rs2_addr;
   logic [1:0]            id_rs_used;
   logic [ADDR_WIDTH-1:0] id_rd_addr;
   logic                  id_rd_wr;
   logic                  id_is_load;
   logic                  ex_branch_taken;
   logic                  dmem_busy;

   logic                  pc_inc;
   logic                  pc_load;
   logic                  if_id_en;
   logic                  id_ex_en;
   logic                  ex_mem_en;
   logic                  mem_wb_en;
   logic                  if_id_flush;
   logic                  id_ex_bubble;
   logic                  wb_wr_en;
   logic [1:0]            fwd_a_sel;
   logic [1:0]            fwd_b_sel;
   logic [CNT_WIDTH-1:0]  stall_cnt;

   modport master (
      output id_valid, id_rs1_addr, id_rs2_addr, id_rs_used, id_rd_addr,
             id_rd_wr, id_is_load, ex_branch_taken, dmem_busy,
      input  pc_inc, pc_load, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_bubble, wb_wr_en, fwd_a_sel, fwd_b_sel,
             stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1_addr, id_rs2_addr, id_rs_used, id_rd_addr,
             id_rd_wr, id_is_load, ex_branch_taken, dmem_busy,
      output pc_inc, pc_load, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_bubble, wb_wr_en, fwd_a_sel, fwd_b_sel,
             stall_cnt
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard detection, forwarding select, branch flush, memory
// freeze and stall counting for a 5-stage in-order pipeline.
//
// Ports:
//   clk  sole clock, all state on the rising edge
//   rst  asynchronous active-high reset; forces every output to 0
//   bus  pipeline_ctrl_if.slave (ID-stage operands, branch/busy requests in;
//        PC, pipeline-register enables, flush/bubble, wb_wr_en, forward
//        selects and stall counter out)
//
// Build option: define PIPELINE_CTRL_FORWARDING_EN to enable operand
// forwarding (only load-use stalls). Without it fwd_*_sel stay 00 and any
// pending writer of an ID source stalls until it retires from WB.
//
// No FSM: control is a priority decode (freeze > branch > stall > free-run)
// over the ID inputs and a three-entry stage scoreboard.
module pipeline_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
) (
   input logic             clk,
   input logic             rst,
   pipeline_ctrl_if.slave  bus
);

   // Stage scoreboard for EX, MEM, WB. is_load only matters while the
   // producer sits in EX (its data is not available yet); once it reaches
   // MEM the loaded value can be forwarded or written, so later stages do
   // not need to remember it.
   logic                  ex_v, mem_v, wb_v;
   logic [ADDR_WIDTH-1:0] ex_rd, mem_rd, wb_rd;
   logic                  ex_wr, mem_wr, wb_wr;
   logic                  ex_ld;
   logic [CNT_WIDTH-1:0]  stall_cnt_q;

   // A stage is a potential producer only if it writes a non-zero register.
   logic ex_prod, mem_prod, wb_prod;
   assign ex_prod  = ex_v  & ex_wr  & (ex_rd  != '0);
   assign mem_prod = mem_v & mem_wr & (mem_rd != '0);
   assign wb_prod  = wb_v  & wb_wr  & (wb_rd  != '0);

   logic use_a, use_b;
   assign use_a = bus.id_valid & bus.id_rs_used[0];
   assign use_b = bus.id_valid & bus.id_rs_used[1];

   logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
   assign ex_hit_a  = ex_prod  & use_a & (ex_rd  == bus.id_rs1_addr);
   assign ex_hit_b  = ex_prod  & use_b & (ex_rd  == bus.id_rs2_addr);
   assign mem_hit_a = mem_prod & use_a & (mem_rd == bus.id_rs1_addr);
   assign mem_hit_b = mem_prod & use_b & (mem_rd == bus.id_rs2_addr);
   assign wb_hit_a  = wb_prod  & use_a & (wb_rd  == bus.id_rs1_addr);
   assign wb_hit_b  = wb_prod  & use_b & (wb_rd  == bus.id_rs2_addr);

   logic load_use;
   assign load_use = ex_ld & (ex_hit_a | ex_hit_b);

   logic       hazard;
   logic [1:0] fwd_a, fwd_b;

`ifdef PIPELINE_CTRL_FORWARDING_EN
   // A value produced in EX is forwardable one cycle later from EX/MEM (01),
   // one produced in MEM from MEM/WB (10). WB producers are covered by the
   // regfile write path, so they never stall and never forward.
   assign hazard = load_use;
   assign fwd_a  = (ex_hit_a & ~ex_ld) ? 2'b01 : (mem_hit_a ? 2'b10 : 2'b00);
   assign fwd_b  = (ex_hit_b & ~ex_ld) ? 2'b01 : (mem_hit_b ? 2'b10 : 2'b00);
   logic unused_wb_hits;
   assign unused_wb_hits = wb_hit_a | wb_hit_b;
`else
   assign hazard = load_use | ex_hit_a | ex_hit_b | mem_hit_a | mem_hit_b
                 | wb_hit_a | wb_hit_b;
   assign fwd_a  = 2'b00;
   assign fwd_b  = 2'b00;
`endif

   // Priority decode; rst gates everything so outputs drop the instant
   // reset rises, without waiting for a clock.
   logic stall_cycle;
   logic bubble;

   always_comb begin
      bus.pc_inc       = 1'b0;
      bus.pc_load      = 1'b0;
      bus.if_id_en     = 1'b0;
      bus.id_ex_en     = 1'b0;
      bus.ex_mem_en    = 1'b0;
      bus.mem_wb_en    = 1'b0;
      bus.if_id_flush  = 1'b0;
      bubble           = 1'b0;
      stall_cycle      = 1'b0;
      if (rst || bus.dmem_busy) begin
         // freeze: everything held, nothing written
      end else if (bus.ex_branch_taken) begin
         bus.pc_load     = 1'b1;
         bus.if_id_en    = 1'b1;
         bus.id_ex_en    = 1'b1;
         bus.ex_mem_en   = 1'b1;
         bus.mem_wb_en   = 1'b1;
         bus.if_id_flush = 1'b1;
         bubble          = 1'b1;
      end else if (hazard) begin
         // ID and IF hold; a NOP goes down the pipe behind the producer
         bus.id_ex_en    = 1'b1;
         bus.ex_mem_en   = 1'b1;
         bus.mem_wb_en   = 1'b1;
         bubble          = 1'b1;
         stall_cycle     = 1'b1;
      end else begin
         bus.pc_inc      = 1'b1;
         bus.if_id_en    = 1'b1;
         bus.id_ex_en    = 1'b1;
         bus.ex_mem_en   = 1'b1;
         bus.mem_wb_en   = 1'b1;
      end
   end

   assign bus.id_ex_bubble = bubble;
   assign bus.wb_wr_en     = ~rst & ~bus.dmem_busy & wb_prod;
   assign bus.fwd_a_sel    = rst ? 2'b00 : fwd_a;
   assign bus.fwd_b_sel    = rst ? 2'b00 : fwd_b;
   assign bus.stall_cnt    = stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_v        <= 1'b0;
         mem_v       <= 1'b0;
         wb_v        <= 1'b0;
         ex_rd       <= '0;
         mem_rd      <= '0;
         wb_rd       <= '0;
         ex_wr       <= 1'b0;
         mem_wr      <= 1'b0;
         wb_wr       <= 1'b0;
         ex_ld       <= 1'b0;
         stall_cnt_q <= '0;
      end else if (!bus.dmem_busy) begin
         ex_v   <= bus.id_valid & ~bubble;
         ex_rd  <= bus.id_rd_addr;
         ex_wr  <= bus.id_rd_wr;
         ex_ld  <= bus.id_is_load;
         mem_v  <= ex_v;
         mem_rd <= ex_rd;
         mem_wr <= ex_wr;
         wb_v   <= mem_v;
         wb_rd  <= mem_rd;
         wb_wr  <= mem_wr;
         if (stall_cycle && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
      end
   end

endmodule
